// File: rtl/multicycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_if
//   Bundle between the multi-cycle RV32I control unit and its datapath.
//   master : control unit side (takes instruction/status, drives controls)
//   slave  : datapath side (supplies instruction/status, takes controls)
//
//   instrCode    32  instruction word from instruction memory
//   btaken        1  branch-compare result from the ALU
//   dataReady     1  data memory done (load or store)
//   pcEn          1  PC register load strobe
//   pcMuxSel      2  next PC: 0 PC+4, 1 PC+imm, 2 ALU result
//   regFileWe     1  register file write enable
//   aluControl    ALU_CTRL_W  ALU operation {funct7[5], funct3}
//   aluSrcMuxSel  1  ALU operand B: 0 rs2, 1 immediate
//   dataWe        1  data memory write request
//   dataRe        1  data memory read request
//   rfWdSrcSel    WB_SEL_W  write-back source
//   illegalInstr  1  sticky trap flag
//   state         3  current FSM state (debug)
// -----------------------------------------------------------------------------
interface multicycle_control_unit_if #(
   parameter int ALU_CTRL_W = 4,
   parameter int WB_SEL_W   = 3
);
   logic [31:0]           instrCode;
   logic                  btaken;
   logic                  dataReady;
   logic                  pcEn;
   logic [1:0]            pcMuxSel;
   logic                  regFileWe;
   logic [ALU_CTRL_W-1:0] aluControl;
   logic                  aluSrcMuxSel;
   logic                  dataWe;
   logic                  dataRe;
   logic [WB_SEL_W-1:0]   rfWdSrcSel;
   logic                  illegalInstr;
   logic [2:0]            state;

   modport master (
      input  instrCode, btaken, dataReady,
      output pcEn, pcMuxSel, regFileWe, aluControl, aluSrcMuxSel,
             dataWe, dataRe, rfWdSrcSel, illegalInstr, state
   );

   modport slave (
      output instrCode, btaken, dataReady,
      input  pcEn, pcMuxSel, regFileWe, aluControl, aluSrcMuxSel,
             dataWe, dataRe, rfWdSrcSel, illegalInstr, state
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//   Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXECUTE -> MEM -> WB,
//   with a sticky TRAP state for unknown opcodes and data-memory timeouts.
//   Controls are combinational functions of the state, the latched
//   instruction register and (in EXECUTE/MEM) btaken / dataReady.
//
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      control/datapath bundle (master side), see the interface file
//
//   Parameters
//     ALU_CTRL_W   width of aluControl
//     WB_SEL_W     width of rfWdSrcSel
//     MEM_TIMEOUT  max MEM wait cycles before trapping, 0 = no timeout
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
   parameter int ALU_CTRL_W  = 4,
   parameter int WB_SEL_W    = 3,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   multicycle_control_unit_if.master bus
);

   localparam logic [2:0] S_FETCH   = 3'd0;
   localparam logic [2:0] S_DECODE  = 3'd1;
   localparam logic [2:0] S_EXECUTE = 3'd2;
   localparam logic [2:0] S_MEM     = 3'd3;
   localparam logic [2:0] S_WB      = 3'd4;
   localparam logic [2:0] S_TRAP    = 3'd5;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_L     = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = '0;

   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   logic [2:0]       state_q, state_d;
   logic [31:0]      ir_q, ir_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       f7b;
   logic       is_r, is_i, is_l, is_s, is_b, is_lui, is_auipc, is_jal, is_jalr;
   logic       op_legal;
   logic       mem_timeout;
   logic [ALU_CTRL_W-1:0] alu_ri;

   logic                  pc_en, rf_we, alu_src, data_we, data_re;
   logic [1:0]            pc_mux;
   logic [ALU_CTRL_W-1:0] alu_ctrl;
   logic [WB_SEL_W-1:0]   wd_sel;

   assign opcode = ir_q[6:0];
   assign funct3 = ir_q[14:12];
   assign f7b    = ir_q[30];

   // Register/immediate fields are consumed by the datapath, not here.
   logic ir_unused;
   assign ir_unused = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

   // Opcode classification. A case with a default makes any x/unknown
   // opcode fall into the illegal bucket instead of propagating.
   always_comb begin
      is_r     = 1'b0;
      is_i     = 1'b0;
      is_l     = 1'b0;
      is_s     = 1'b0;
      is_b     = 1'b0;
      is_lui   = 1'b0;
      is_auipc = 1'b0;
      is_jal   = 1'b0;
      is_jalr  = 1'b0;
      case (opcode)
         OP_R:     is_r     = 1'b1;
         OP_I:     is_i     = 1'b1;
         OP_L:     is_l     = 1'b1;
         OP_S:     is_s     = 1'b1;
         OP_B:     is_b     = 1'b1;
         OP_LUI:   is_lui   = 1'b1;
         OP_AUIPC: is_auipc = 1'b1;
         OP_JAL:   is_jal   = 1'b1;
         OP_JALR:  is_jalr  = 1'b1;
         default:  ;
      endcase
   end

   assign op_legal = is_r | is_i | is_l | is_s | is_b |
                     is_lui | is_auipc | is_jal | is_jalr;

   // Only shifts (funct3 = 101) carry funct7[5] for I-type; R-type always does.
   assign alu_ri = (is_r || funct3 == 3'b101) ? ALU_CTRL_W'({f7b, funct3})
                                              : ALU_CTRL_W'({1'b0, funct3});

   // Fires on the waiting cycle that brings the wait count to MEM_TIMEOUT.
   assign mem_timeout = (MEM_TIMEOUT != 0) && !bus.dataReady &&
                        (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
      cnt_d     = '0;
      pc_en     = 1'b0;
      pc_mux    = 2'd0;
      rf_we     = 1'b0;
      alu_ctrl  = ALU_ADD;
      alu_src   = 1'b0;
      data_we   = 1'b0;
      data_re   = 1'b0;
      wd_sel    = '0;

      case (state_q)
         S_FETCH: begin
            ir_d    = bus.instrCode;
            state_d = S_DECODE;
         end

         S_DECODE: state_d = op_legal ? S_EXECUTE : S_TRAP;

         S_EXECUTE: begin
            if (is_r) begin
               alu_ctrl = alu_ri;
               state_d  = S_WB;
            end else if (is_i) begin
               alu_ctrl = alu_ri;
               alu_src  = 1'b1;
               state_d  = S_WB;
            end else if (is_l || is_s) begin
               alu_src  = 1'b1;           // address = rs1 + imm
               state_d  = S_MEM;
            end else if (is_b) begin
               alu_ctrl = ALU_CTRL_W'({1'b0, funct3});
               pc_en    = 1'b1;
               pc_mux   = bus.btaken ? 2'd1 : 2'd0;
               state_d  = S_FETCH;
            end else if (op_legal) begin
               state_d  = S_WB;           // LUI / AUIPC / JAL / JALR
            end else begin
               state_d  = S_TRAP;
            end
         end

         S_MEM: begin
            alu_src = 1'b1;               // keep the address stable while waiting
            if (bus.dataReady) begin
               data_we = is_s;
               data_re = is_l;
               if (is_s) begin
                  pc_en   = 1'b1;         // stores retire here, no WB
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (mem_timeout) begin
               state_d = S_TRAP;          // request drops on the trapping cycle
            end else begin
               data_we = is_s;
               data_re = is_l;
               cnt_d   = (MEM_TIMEOUT != 0) ? cnt_q + CNT_W'(1) : '0;
            end
         end

         S_WB: begin
            rf_we   = 1'b1;
            pc_en   = 1'b1;
            state_d = S_FETCH;
            if (is_r || is_i) begin
               // ALU result is written back combinationally, so hold its op.
               alu_ctrl = alu_ri;
               alu_src  = is_i;
               wd_sel   = WB_SEL_W'(0);
            end else if (is_l) begin
               wd_sel   = WB_SEL_W'(1);
            end else if (is_lui) begin
               wd_sel   = WB_SEL_W'(2);
            end else if (is_auipc) begin
               wd_sel   = WB_SEL_W'(3);
            end else if (is_jal) begin
               wd_sel   = WB_SEL_W'(4);
               pc_mux   = 2'd1;
            end else if (is_jalr) begin
               wd_sel   = WB_SEL_W'(4);
               pc_mux   = 2'd2;
               alu_src  = 1'b1;           // target = rs1 + imm
            end
         end

         S_TRAP: ;                        // parked until reset

         default: state_d = S_TRAP;
      endcase

      if (state_d == S_TRAP) illegal_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_FETCH;
         ir_q      <= '0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.pcEn         = pc_en;
   assign bus.pcMuxSel     = pc_mux;
   assign bus.regFileWe    = rf_we;
   assign bus.aluControl   = alu_ctrl;
   assign bus.aluSrcMuxSel = alu_src;
   assign bus.dataWe       = data_we;
   assign bus.dataRe       = data_re;
   assign bus.rfWdSrcSel   = wd_sel;
   assign bus.illegalInstr = illegal_q;
   assign bus.state        = state_q;

endmodule
